// File: rtl/cd_multi_div.sv
`default_nettype none
// ============================================================================
// Module   : cd_multi_div
// Brief    : NUM_CH-channel run-time programmable clock divider with per-channel
//            tick strobes; divisor changes commit glitch-free at each wrap.
//            Optional macro CD_SYNC_EN maps a phase-realign command at NUM_CH+1.
// Revision : 1.0 - initial release
// ============================================================================
module cd_multi_div #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 14,
    parameter int ADDR_W  = 4,
    parameter int DEF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DIV_W-1:0]  c_data,
    input  logic              c_valid,
    output logic              c_ready,
    output logic              c_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [ADDR_W-1:0] C_EN_ADDR   = ADDR_W'(NUM_CH);
    localparam logic [DIV_W-1:0]  C_DEF_DIV   = DIV_W'(DEF_DIV);
`ifdef CD_SYNC_EN
    localparam logic [ADDR_W-1:0] C_SYNC_ADDR = ADDR_W'(NUM_CH + 1);
`endif

    logic              r_ready;
    logic              r_err;
    logic [NUM_CH-1:0] r_en_mask;
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;
    logic [DIV_W-1:0]  r_cnt      [NUM_CH];
    logic [DIV_W-1:0]  r_div_act  [NUM_CH];
    logic [DIV_W-1:0]  r_div_pend [NUM_CH];

    logic              w_xfer;
    logic              w_en_wr;
    logic              w_sync;
    logic              w_mapped;
    logic [NUM_CH-1:0] w_div_wr;
    logic [NUM_CH-1:0] w_kill;

    always_comb begin
        w_xfer  = c_valid && r_ready;
        w_en_wr = w_xfer && (c_addr == C_EN_ADDR);
`ifdef CD_SYNC_EN
        w_sync  = w_xfer && (c_addr == C_SYNC_ADDR);
`else
        w_sync  = 1'b0;
`endif
        w_div_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_div_wr[i] = w_xfer && (c_addr == ADDR_W'(i));
        end
        w_mapped = (|w_div_wr) || w_en_wr || w_sync;
        // A mask write that clears a bit wins over a wrap in the same cycle
        w_kill   = w_en_wr ? ~c_data[NUM_CH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_en_mask <= '1;
            r_clk_out <= '0;
            r_tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]      <= '0;
                r_div_act[i]  <= C_DEF_DIV;
                r_div_pend[i] <= C_DEF_DIV;
            end
        end else begin
            r_ready <= !w_xfer;
            r_err   <= w_xfer && !w_mapped;
            if (w_en_wr) begin
                r_en_mask <= c_data[NUM_CH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_div_wr[i]) begin
                    r_div_pend[i] <= c_data;
                end
                // Idle channels track the pending divisor so a restart uses it
                if (w_sync || w_kill[i] || !r_en_mask[i] || (r_div_act[i] == '0)) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= 1'b0;
                    r_tick[i]    <= 1'b0;
                    r_div_act[i] <= r_div_pend[i];
                end else if (r_cnt[i] == r_div_act[i] - DIV_W'(1)) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= ~r_clk_out[i];
                    r_tick[i]    <= 1'b1;
                    r_div_act[i] <= r_div_pend[i];
                end else begin
                    r_cnt[i]     <= r_cnt[i] + DIV_W'(1);
                    r_tick[i]    <= 1'b0;
                end
            end
        end
    end

    assign c_ready = r_ready;
    assign c_err   = r_err;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule
`default_nettype wire
